// File: rtl/rect_fill_engine_if.sv
// Command and framebuffer-write bus of rect_fill_engine.
// master = command source and RAM side, slave = the engine.
interface rect_fill_engine_if #(
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 17,
  parameter int NCH    = 3,
  parameter int CW     = 2
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_mode;
  logic [X_W-1:0]        cmd_x1;
  logic [X_W-1:0]        cmd_x2;
  logic [Y_W-1:0]        cmd_y1;
  logic [Y_W-1:0]        cmd_y2;
  logic [NCH*CW-1:0]     cmd_color;
  logic                  abort;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [NCH*CW-1:0]     wr_data;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_mode, cmd_x1, cmd_x2, cmd_y1, cmd_y2, cmd_color, abort,
    input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_x1, cmd_x2, cmd_y1, cmd_y2, cmd_color, abort,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser: visits each pixel of a clipped rectangle once per clock
// and emits registered framebuffer writes with incremental addressing.
module rect_fill_engine #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 17,
  parameter int NCH    = 3,
  parameter int CW     = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  rect_fill_engine_if.slave bus
);
  localparam int                DW         = NCH * CW;
  localparam logic [X_W-1:0]    X_MAX      = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_MAX      = Y_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_RES);
  localparam logic [1:0]        MODE_CLEAR = 2'b01;
  localparam logic [1:0]        MODE_OUTL  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [X_W-1:0]    x1_q, x1_d, x2_q, x2_d, x_q, x_d;
  logic [Y_W-1:0]    y1_q, y1_d, y2_q, y2_d, y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]     color_q, color_d, wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic [X_W-1:0]    sx1, sx2;
  logic [Y_W-1:0]    sy1, sy2;
  logic              empty;
  logic              on_edge;

  // Clear overrides the bounds; otherwise only the far corner needs clipping.
  always_comb begin
    if (mode_q == MODE_CLEAR) begin
      sx1 = '0;
      sy1 = '0;
      sx2 = X_MAX;
      sy2 = Y_MAX;
    end else begin
      sx1 = x1_q;
      sy1 = y1_q;
      sx2 = (x2_q > X_MAX) ? X_MAX : x2_q;
      sy2 = (y2_q > Y_MAX) ? Y_MAX : y2_q;
    end
    empty   = (sx1 > sx2) || (sy1 > sy2) || (sx1 > X_MAX) || (sy1 > Y_MAX);
    on_edge = (x_q == x1_q) || (x_q == x2_q) || (y_q == y1_q) || (y_q == y2_q);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    y1_d       = y1_q;
    y2_d       = y2_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    color_d    = color_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          mode_d    = bus.cmd_mode;
          x1_d      = bus.cmd_x1;
          x2_d      = bus.cmd_x2;
          y1_d      = bus.cmd_y1;
          y2_d      = bus.cmd_y2;
          color_d   = bus.cmd_color;
          wr_data_d = bus.cmd_color;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (empty) begin
          state_d = S_DONE;
        end else begin
          x1_d       = sx1;
          x2_d       = sx2;
          y1_d       = sy1;
          y2_d       = sy2;
          x_d        = sx1;
          y_d        = sy1;
          row_base_d = ADDR_W'(sy1) * ROW_STEP;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        // Outline still walks the interior so timing matches fill; it just suppresses the strobe.
        wr_en_d = (mode_q != MODE_OUTL) || on_edge;
        if (wr_en_d) begin
          wr_addr_d = row_base_q + ADDR_W'(x_q);
        end
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (x_q == x2_q) begin
          if (y_q == y2_q) begin
            state_d = S_DONE;
          end else begin
            x_d        = x1_q;
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q + ROW_STEP;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      color_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_base_q  <= row_base_d;
      color_q     <= color_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cmd_ready = cmd_ready_q;
endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
Parametrised rectangle rasteriser that writes a packed-colour framebuffer RAM. It takes one command at a time through a valid/ready handshake. It visits only the pixels inside the clipped rectangle, one per clock, with incremental addressing and no divide or modulo. It supports solid fill, outline and full-screen clear. It sits between the UART command decoder and the colour RAMs, replacing the full-frame scan-and-compare writer.

Parameters:
H_RES, 320, framebuffer width in pixels
V_RES, 240, framebuffer height in pixels
X_W, 9, coordinate width for x (must hold H_RES-1)
Y_W, 8, coordinate width for y (must hold V_RES-1)
ADDR_W, 17, write address width (must hold H_RES*V_RES-1)
NCH, 3, colour channels
CW, 2, bits per channel

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command (high only in IDLE)
cmd_mode  in  2  00 fill, 01 clear, 10 outline, 11 reserved (treated as fill)
cmd_x1, cmd_x2  in  X_W  inclusive column bounds
cmd_y1, cmd_y2  in  Y_W  inclusive row bounds
cmd_color  in  NCH*CW  packed colour, channel 0 (R) in the MSBs
abort  in  1  cancel the active command
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  pixel address = y*H_RES + x
wr_data  out  NCH*CW  colour to write
busy  out  1  high in SETUP/FILL/DONE
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, cmd_ready=1.
- States: IDLE -> SETUP -> FILL -> DONE -> IDLE.
- IDLE: cmd_ready=1. A command is accepted on an edge where cmd_valid=1; fields are latched; next state is SETUP. abort is ignored in IDLE, including when it arrives in the same cycle as cmd_valid.
- SETUP (1 cycle): clip x2 to min(x2,H_RES-1) and y2 to min(y2,V_RES-1). Clear mode forces x1=0, y1=0, x2=H_RES-1, y2=V_RES-1 and ignores the coordinate inputs. If x1>x2, y1>y2, x1>=H_RES or y1>=V_RES, the rectangle is empty: go straight to DONE with no writes. Otherwise load row_base=y1*H_RES (one multiply, registered), x=x1, y=y1, then go to FILL.
- FILL: one pixel per cycle, raster order. After x==x2: x=x1, y++, row_base+=H_RES. The last pixel is (x2,y2); the cycle after it, go to DONE.
- Write outputs are registered. wr_en/wr_addr/wr_data for pixel k appear on the cycle after the FILL cycle that visits it. The first write is therefore high in cycle accept+3: accept edge, SETUP, first FILL, output.
- Fill and clear: wr_en=1 for every visited pixel.
- Outline: wr_en=1 only when x==x1, x==x2, y==y1 or y==y2. Interior pixels are still visited and take cycles, with wr_en=0.
- wr_data = latched cmd_color for the whole command. wr_addr holds its last value when wr_en=0.
- DONE (1 cycle): done=1, busy=1, cmd_ready=0. The final write strobe and done are high in the same cycle. Then IDLE.
- Empty rectangle: done is high at accept+2 and wr_en is never asserted.
- abort high in SETUP or FILL: on the next edge go to IDLE with no done pulse. The pixel visited in the abort cycle is still written on the following cycle; no further writes.
- Reset asserted mid-command: wr_en drops immediately (asynchronous) and the command is lost.
- Single-pixel rectangle (x1=x2, y1=y2): exactly one write, in fill and in outline.
- Cycles from accept to done = 2 + visited pixel count.

Test Plan:
- Fill (10,20)-(12,21), colour 0x2D -> writes to 6410, 6411, 6412, 6730, 6731, 6732, all data 0x2D, on consecutive cycles accept+3..accept+8; done at accept+8; cmd_ready returns high at accept+9.
- Clip: fill (318,239)-(400,300) -> exactly 2 writes, at 76798 and 76799; done at accept+4.
- Empty: x1=5, x2=3 -> zero writes, done at accept+2. Also x1=320 -> zero writes.
- Outline (0,0)-(2,2), colour 0x3F -> 8 writes at 0, 1, 2, 320, 322, 640, 641, 642; address 321 never strobed; done at accept+11.
- Clear, colour 0x00 -> 76800 writes covering addresses 0..76799 in order; done at accept+76802; cmd_valid held high during busy is not accepted until IDLE.
- Abort on the 5th FILL cycle of a 100-pixel fill -> exactly 5 writes, no done pulse, cmd_ready=1 next cycle. Repeat with reset_n pulsed low mid-fill -> wr_en=0 asynchronously and outputs at reset values.
